// File: rtl/sipo_deser_pkg.sv
// Shared types and constants for the serial-in parallel-out deserializer.
package sipo_deser_pkg;

  localparam int DESER_WIDTH = 4;

  typedef logic [0:0] deser_state_t;
  localparam deser_state_t EMPTY = 1'b0;
  localparam deser_state_t FULL  = 1'b1;

  // Ceiling log2, evaluated at elaboration time for counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Parallel-load holding register for the deserializer output word.
// One-edge load latency; holds its value whenever load is low.
module sipo_hold_reg #(
  parameter int WIDTH = 4
)(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Assembles WIDTH-bit words from a serial stream; word appears on q one edge after its last bit.
// Double-buffered: shifting never stalls; a word completing while q is unconsumed is dropped and flagged.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = clog2(WIDTH)
)(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             flush,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             overflow
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  deser_state_t     state_q;
  deser_state_t     state_d;
  logic             accept;
  logic             complete;
  logic             load;
  logic             ovf_set;

  assign accept   = sin_valid && !flush;
  assign complete = accept && (bit_cnt == CW'(WIDTH - 1));

  // shift_next already includes this cycle's bit, so on completion it is the finished word.
  assign shift_next = MSB_FIRST ? ((shift_q << 1) | WIDTH'(sin))
                                : ((shift_q >> 1) | (WIDTH'(sin) << (WIDTH - 1)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      if (complete) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else begin
        shift_q <= shift_next;
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // A completion is taken whenever the holding slot is free or being drained this cycle.
  assign load    = complete && ((state_q == EMPTY) || out_ready);
  assign ovf_set = complete && (state_q == FULL) && !out_ready;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= EMPTY;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      overflow <= ovf_set || (overflow && !ovf_clr);
    end
  end

  assign out_valid = (state_q == FULL);

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (load),
    .d     (shift_next),
    .q     (q)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Drives MSB-first and LSB-first deserializers in parallel against a word-level reference model.
module tb_sipo_deser;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] q_m, q_l;
  logic         vld_m, vld_l, ovf_m, ovf_l;
  logic [1:0]   cnt_m, cnt_l;

  int total = 0;
  int bad = 0;

  bit           mbits[$];
  logic [W-1:0] m_q_m, m_q_l;
  logic         m_valid, m_ovf;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .q(q_m), .out_valid(vld_m),
    .bit_cnt(cnt_m), .overflow(ovf_m));

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr_n(clr_n), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .out_ready(out_ready), .ovf_clr(ovf_clr), .q(q_l), .out_valid(vld_l),
    .bit_cnt(cnt_l), .overflow(ovf_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mbits.delete();
    m_q_m = '0;
    m_q_l = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q_msb"}, 32'(q_m), 32'(m_q_m));
    chk({tag, ".q_lsb"}, 32'(q_l), 32'(m_q_l));
    chk({tag, ".vld_msb"}, 32'(vld_m), 32'(m_valid));
    chk({tag, ".vld_lsb"}, 32'(vld_l), 32'(m_valid));
    chk({tag, ".cnt_msb"}, 32'(cnt_m), 32'(mbits.size()));
    chk({tag, ".cnt_lsb"}, 32'(cnt_l), 32'(mbits.size()));
    chk({tag, ".ovf_msb"}, 32'(ovf_m), 32'(m_ovf));
    chk({tag, ".ovf_lsb"}, 32'(ovf_l), 32'(m_ovf));
  endtask

  // One clock: apply inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic s, input logic v, input logic f,
                      input logic r, input logic c);
    bit           done;
    bit           ovf_ev;
    logic [W-1:0] wm, wl;
    sin = s; sin_valid = v; flush = f; out_ready = r; ovf_clr = c;
    @(posedge clk);
    done = 1'b0;
    ovf_ev = 1'b0;
    wm = '0;
    wl = '0;
    if (f) begin
      mbits.delete();
    end else if (v) begin
      mbits.push_back(s);
      if (mbits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = mbits[i];
          wl[i] = mbits[i];
        end
        mbits.delete();
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_q_m = wm;
        m_q_l = wl;
        m_valid = 1'b1;
      end else begin
        ovf_ev = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    m_ovf = ovf_ev ? 1'b1 : (c ? 1'b0 : m_ovf);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [W-1:0] w, input logic r);
    for (int i = W - 1; i >= 0; i--) step(tag, w[i], 1'b1, 1'b0, r, 1'b0);
  endtask

  int pulses;
  int last_pulse;
  int gap_bad;

  initial begin
    model_reset();
    #2;
    chk("rst.q", 32'(q_m), 32'd0);
    chk("rst.vld", 32'(vld_m), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    // Reset mid-word discards partial bits.
    step("t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    clr_n = 1'b0;
    #2;
    model_reset();
    check_all("t1.rst");
    @(negedge clk);
    clr_n = 1'b1;
    send_word("t1.fresh", 4'b1001, 1'b1);
    chk("t1.word", 32'(q_m), 32'h9);

    // Basic ordering: 1,0,1,1.
    step("t2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("t2", 4'b1011, 1'b1);
    chk("t2.msb", 32'(q_m), 32'hB);
    chk("t2.lsb", 32'(q_l), 32'hD);
    chk("t2.vld", 32'(vld_m), 32'd1);

    // Gaps, then flush, then a clean word.
    step("t3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t3.fl", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3.cnt_after_flush", 32'(cnt_m), 32'd0);
    send_word("t3", 4'b0110, 1'b1);
    chk("t3.msb", 32'(q_m), 32'h6);
    chk("t3.lsb", 32'(q_l), 32'h6);

    // Backpressure: second word dropped.
    step("t4", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("t4", 4'b1010, 1'b0);
    send_word("t4", 4'b0101, 1'b0);
    chk("t4.q_held", 32'(q_m), 32'hA);
    chk("t4.ovf", 32'(ovf_m), 32'd1);
    step("t4.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4.vld_drop", 32'(vld_m), 32'd0);
    chk("t4.q_kept", 32'(q_m), 32'hA);
    step("t4.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4.ovf_clr", 32'(ovf_m), 32'd0);

    // Accept and complete in the same cycle.
    send_word("t5", 4'b0011, 1'b0);
    step("t5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("t5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5.q", 32'(q_m), 32'hC);
    chk("t5.vld", 32'(vld_m), 32'd1);
    chk("t5.ovf", 32'(ovf_m), 32'd0);

    // Streaming: 8 words back-to-back.
    step("t6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    last_pulse = -1;
    gap_bad = 0;
    for (int k = 0; k < 8 * W; k++) begin
      step("t6", 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 1'b0);
      if (vld_m) begin
        if (last_pulse >= 0 && k - last_pulse != W) gap_bad++;
        last_pulse = k;
        pulses++;
      end
    end
    chk("t6.pulses", 32'(pulses), 32'd8);
    chk("t6.gap", 32'(gap_bad), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in, parallel-out deserializer that sits directly upstream of the team's 4-bit parallel-load register. It assembles WIDTH-bit words from a one-bit-per-cycle serial stream and presents each word with a valid/ready handshake. Assembly and output holding are double-buffered, so shifting continues while a finished word waits for the consumer.

Parameters:
WIDTH, 4, word width in bits; legal values are 2..32.
MSB_FIRST, 1, 1 = the first received bit lands in q[WIDTH-1]; 0 = the first received bit lands in q[0].

Ports:
clk  input  1  rising-edge clock.
clr_n  input  1  asynchronous active-low reset; clears all state immediately.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on this clock edge.
flush  input  1  synchronous abort of the partially assembled word.
out_ready  input  1  consumer accepts q this cycle.
ovf_clr  input  1  synchronous clear of the sticky overflow flag.
q  output  WIDTH  completed word, registered.
out_valid  output  1  q holds an unconsumed word.
bit_cnt  output  CW  bits assembled so far, 0..WIDTH-1, where CW = clog2(WIDTH).
overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset:
  - Clock is clk; reset is clr_n, asynchronous and active-low.
  - While clr_n=0: q=0, out_valid=0, bit_cnt=0, overflow=0, shift register=0, FSM=EMPTY.
  - Reset asserted mid-word discards the partial word; no output pulse results.
- Shift path:
  - When sin_valid=1 and flush=0, sin enters the shift register.
  - MSB_FIRST=1 shifts left with sin entering bit 0; MSB_FIRST=0 shifts right with sin entering bit WIDTH-1.
  - bit_cnt increments on each accepted bit.
  - When the accepted bit is the WIDTH-th (bit_cnt==WIDTH-1), a completion event fires, bit_cnt wraps to 0 and the shift register clears.
  - Cycles with sin_valid=0 hold all shift state; gaps are allowed anywhere in a word.
- flush:
  - Clears bit_cnt and the shift register on the next edge, and the sin bit in that cycle is ignored.
  - Does not touch q, out_valid or overflow.
  - flush has priority over sin_valid.
- Output FSM (state EMPTY / FULL; out_valid = (state==FULL)):
  - EMPTY + completion: q <= assembled word, go to FULL. Latency is one edge: the word is visible on q the cycle after the last bit is sampled.
  - FULL + out_ready=1, no completion: go to EMPTY. q holds its last value (not cleared).
  - FULL + out_ready=1 + completion in the same cycle: q <= new word, stay FULL, no overflow.
  - FULL + out_ready=0 + completion: new word dropped, q unchanged, overflow <= 1.
  - EMPTY + out_ready: no effect.
- overflow:
  - Sticky; cleared only by ovf_clr or reset.
  - If ovf_clr and a new overflow event occur in the same cycle, overflow stays 1 (set wins).
- Throughput: sustains one word every WIDTH cycles with out_ready tied high, no bubbles.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package holds:
  - the state typedef (EMPTY=1'b0, FULL=1'b1);
  - a clog2 function for CW;
  - a default width constant DESER_WIDTH=4.
- One sub-module, sipo_hold_reg: a WIDTH-bit parallel-load register with load enable and asynchronous active-low clear. It implements q.
- The shift register, counter and FSM stay in the top level.

Test Plan:
1. Reset: assert clr_n=0 mid-word after 2 bits, then release -> q=0, out_valid=0, bit_cnt=0, overflow=0; the next 4 bits form a fresh word.
2. MSB_FIRST=1, out_ready=1, serial 1,0,1,1 on consecutive cycles -> q=4'b1011 with out_valid=1 one cycle after the 4th bit. Repeat with MSB_FIRST=0 -> q=4'b1101.
3. Gaps and flush: sin_valid pattern 1,0,0,1 carrying bits 1,1, then flush, then bits 0,1,1,0 -> q=4'b0110; bit_cnt=0 immediately after flush.
4. Backpressure: out_ready=0, send 4'b1010 then 4'b0101 -> q stays 4'b1010, overflow=1. Then out_ready=1 -> out_valid=0 next cycle. Then ovf_clr=1 -> overflow=0.
5. Simultaneous accept and complete: word 4'b0011 held (FULL), out_ready=1 in the same cycle as the 4th bit of 4'b1100 -> q=4'b1100, out_valid stays 1, overflow=0.
6. Streaming: 8 back-to-back words with out_ready=1 -> 8 out_valid pulses spaced 4 cycles apart, with data matching in order.
